// File: rtl/cache_refill_ctrl_pkg.sv
// Shared address layout, line geometry and state encoding for the cache refill controller.
// The slicing macros take a 32-bit byte address and return its tag, set index or byte offset.
`ifndef CACHE_REFILL_CTRL_MACROS
`define CACHE_REFILL_CTRL_MACROS
`define CRC_ADDR_TAG(a) a[cache_refill_ctrl_pkg::ADDR_BITS-1 -: cache_refill_ctrl_pkg::TAG_BITS]
`define CRC_ADDR_INDEX(a) a[cache_refill_ctrl_pkg::OFFSET_BITS +: cache_refill_ctrl_pkg::SET_BITS]
`define CRC_ADDR_OFFSET(a) a[cache_refill_ctrl_pkg::OFFSET_BITS-1:0]
`endif

package cache_refill_ctrl_pkg;

  localparam int ADDR_BITS    = 32;
  localparam int SET_BITS     = 3;
  localparam int OFFSET_BITS  = 5;
  localparam int TAG_BITS     = ADDR_BITS - SET_BITS - OFFSET_BITS;
  localparam int WORDS        = 1 << (OFFSET_BITS - 2);
  localparam int DEFAULT_WAYS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_WRITE
  } refill_state_e;

  // Memory bursts always start at the first byte of the line.
  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_victim_sel.sv
// Combinational victim chooser: the lowest invalid way wins, otherwise the round-robin way.
// evict_valid tells the parent that a live line is being replaced so it can advance its pointer.
module refill_victim_sel #(
  parameter int WAYS  = 4,
  parameter int PTR_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  set_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [WAYS-1:0]  victim_oh,
  output logic             evict_valid
);

  logic found;

  always_comb begin
    victim_oh = '0;
    found     = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!set_valid[i] && !found) begin
        victim_oh[i] = 1'b1;
        found        = 1'b1;
      end
    end
    evict_valid = !found;
    if (!found) begin
      victim_oh[rr_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill controller: accepts a miss, bursts the line in from memory and
// writes tag, data and valid of the chosen victim way in one cycle.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int WAYS = DEFAULT_WAYS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [31:0]           miss_addr,
  input  logic [WAYS-1:0]       set_valid,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  output logic [7:0]            mem_req_len,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rdata_last,
  output logic [WAYS-1:0]       line_wen,
  output logic [SET_BITS-1:0]   line_waddr,
  output logic [TAG_BITS-1:0]   line_wtag,
  output logic [32*WORDS-1:0]   line_wdata,
  output logic                  refill_done,
  output logic                  refill_err
);

  localparam int PTR_W = $clog2(WAYS);
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] WORDS_C    = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(WORDS - 1);

  refill_state_e          state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORDS-1:0][31:0] buf_q, buf_d;
  logic [WAYS-1:0]        victim_q, victim_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [SET_BITS-1:0]    set_q, set_d;
  logic [31:0]            req_addr_q, req_addr_d;
  logic                   miss_ready_q, miss_ready_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic                   mem_rdata_ready_q, mem_rdata_ready_d;
  logic [WAYS-1:0]        line_wen_q, line_wen_d;
  logic                   refill_done_q, refill_done_d;
  logic                   refill_err_q, refill_err_d;

  logic [WAYS-1:0]        sel_victim;
  logic                   sel_evict_valid;
  logic                   unused_offset;

  assign unused_offset = ^`CRC_ADDR_OFFSET(miss_addr);

  refill_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim_sel (
    .set_valid   (set_valid),
    .rr_ptr      (rr_ptr_q),
    .victim_oh   (sel_victim),
    .evict_valid (sel_evict_valid)
  );

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    cnt_d             = cnt_q;
    buf_d             = buf_q;
    victim_d          = victim_q;
    tag_d             = tag_q;
    set_d             = set_q;
    req_addr_d        = req_addr_q;
    miss_ready_d      = miss_ready_q;
    mem_req_valid_d   = mem_req_valid_q;
    mem_rdata_ready_d = mem_rdata_ready_q;
    line_wen_d        = '0;
    refill_done_d     = 1'b0;
    refill_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_valid && miss_ready_q) begin
          tag_d           = `CRC_ADDR_TAG(miss_addr);
          set_d           = `CRC_ADDR_INDEX(miss_addr);
          req_addr_d      = line_align(miss_addr);
          victim_d        = sel_victim;
          buf_d           = '0;
          cnt_d           = '0;
          miss_ready_d    = 1'b0;
          mem_req_valid_d = 1'b1;
          state_d         = ST_REQ;
          if (sel_evict_valid) begin
            rr_ptr_d = rr_ptr_q + 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d   = 1'b0;
          mem_rdata_ready_d = 1'b1;
          state_d           = ST_RECV;
        end
      end

      // cnt saturates at WORDS so overlong bursts are drained without touching the buffer.
      ST_RECV: begin
        if (mem_rdata_valid) begin
          if (cnt_q != WORDS_C) begin
            buf_d[cnt_q[IDX_W-1:0]] = mem_rdata;
            cnt_d                   = cnt_q + 1'b1;
          end
          if (mem_rdata_last) begin
            mem_rdata_ready_d = 1'b0;
            line_wen_d        = victim_q;
            refill_done_d     = 1'b1;
            refill_err_d      = (cnt_q != LAST_IDX_C);
            state_d           = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        miss_ready_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        miss_ready_d      = 1'b1;
        mem_req_valid_d   = 1'b0;
        mem_rdata_ready_d = 1'b0;
        state_d           = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      rr_ptr_q          <= '0;
      cnt_q             <= '0;
      buf_q             <= '0;
      victim_q          <= '0;
      tag_q             <= '0;
      set_q             <= '0;
      req_addr_q        <= '0;
      miss_ready_q      <= 1'b1;
      mem_req_valid_q   <= 1'b0;
      mem_rdata_ready_q <= 1'b0;
      line_wen_q        <= '0;
      refill_done_q     <= 1'b0;
      refill_err_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      cnt_q             <= cnt_d;
      buf_q             <= buf_d;
      victim_q          <= victim_d;
      tag_q             <= tag_d;
      set_q             <= set_d;
      req_addr_q        <= req_addr_d;
      miss_ready_q      <= miss_ready_d;
      mem_req_valid_q   <= mem_req_valid_d;
      mem_rdata_ready_q <= mem_rdata_ready_d;
      line_wen_q        <= line_wen_d;
      refill_done_q     <= refill_done_d;
      refill_err_q      <= refill_err_d;
    end
  end

  assign miss_ready      = miss_ready_q;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_len     = 8'(WORDS - 1);
  assign mem_rdata_ready = mem_rdata_ready_q;
  assign line_wen        = line_wen_q;
  assign line_waddr      = set_q;
  assign line_wtag       = tag_q;
  assign line_wdata      = buf_q;
  assign refill_done     = refill_done_q;
  assign refill_err      = refill_err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a vector table of refills plus hand-written
// sequences for reset abort and a miss held across a refill; line writes go through a scoreboard.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic [3:0]   set_valid;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic [7:0]   mem_req_len;
  logic         mem_rdata_valid;
  logic         mem_rdata_ready;
  logic [31:0]  mem_rdata;
  logic         mem_rdata_last;
  logic [3:0]   line_wen;
  logic [2:0]   line_waddr;
  logic [23:0]  line_wtag;
  logic [255:0] line_wdata;
  logic         refill_done;
  logic         refill_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.WAYS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_addr       (miss_addr),
    .set_valid       (set_valid),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_len     (mem_req_len),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_last  (mem_rdata_last),
    .line_wen        (line_wen),
    .line_waddr      (line_waddr),
    .line_wtag       (line_wtag),
    .line_wdata      (line_wdata),
    .refill_done     (refill_done),
    .refill_err      (refill_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sv;
    int          nbeats;
    int          req_delay;
    bit          gaps;
    logic [31:0] base;
    logic [3:0]  exp_wen;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]   wen;
    logic [2:0]   waddr;
    logic [23:0]  wtag;
    logic [255:0] wdata;
    bit           err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  function automatic void checkOutput(input string name, input logic [255:0] act,
                                      input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Every refill_done pulse must match the oldest pending expectation; line_wen is quiet otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (refill_done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got refill_done=1 expected no pending refill");
      end else begin
        e = sb.pop_front();
        checkOutput("line_wen",   256'(line_wen),   256'(e.wen));
        checkOutput("line_waddr", 256'(line_waddr), 256'(e.waddr));
        checkOutput("line_wtag",  256'(line_wtag),  256'(e.wtag));
        checkOutput("line_wdata", line_wdata,       e.wdata);
        checkOutput("refill_err", 256'(refill_err), 256'(e.err));
      end
    end else begin
      checkOutput("idle_wen", 256'(line_wen), 256'(0));
    end
  end

  // Wait until the controller is idle, issue one miss and feed the burst; optionally keep
  // miss_valid asserted with next_addr so the following miss is pending during this refill.
  task automatic applyStimulus(input vec_t v, input bit hold, input logic [31:0] next_addr);
    exp_t        e;
    int          waited;
    logic [31:0] aligned;
    aligned = {v.addr[31:5], 5'b0};
    e.wen   = v.exp_wen;
    e.waddr = v.addr[7:5];
    e.wtag  = v.addr[31:8];
    e.err   = v.exp_err;
    e.wdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < v.nbeats) e.wdata[32*i +: 32] = v.base + 32'(i);
    end

    waited = 0;
    while (miss_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait", 256'(miss_ready), 256'(1));

    sb.push_back(e);
    miss_valid = 1'b1;
    miss_addr  = v.addr;
    set_valid  = v.sv;
    @(posedge clk); #1;
    if (hold) miss_addr = next_addr;
    else miss_valid = 1'b0;

    for (int k = 0; k < v.req_delay; k++) begin
      @(negedge clk);
      checkOutput("req_wait_valid", 256'(mem_req_valid), 256'(1));
      checkOutput("req_wait_addr",  256'(mem_req_addr),  256'(aligned));
      checkOutput("req_wait_busy",  256'(miss_ready),    256'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("req_valid", 256'(mem_req_valid), 256'(1));
    checkOutput("req_addr",  256'(mem_req_addr),  256'(aligned));
    checkOutput("req_len",   256'(mem_req_len),   256'(7));
    checkOutput("req_busy",  256'(miss_ready),    256'(0));
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;

    for (int b = 0; b < v.nbeats; b++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 2)) begin
          mem_rdata_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      mem_rdata_valid = 1'b1;
      mem_rdata       = v.base + 32'(b);
      mem_rdata_last  = (b == v.nbeats - 1);
      @(negedge clk);
      checkOutput("rdata_ready", 256'(mem_rdata_ready), 256'(1));
      checkOutput("recv_busy",   256'(miss_ready),      256'(0));
      @(posedge clk); #1;
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;

    @(negedge clk);
    checkOutput("done_cycle", 256'(refill_done), 256'(1));
    checkOutput("write_busy", 256'(miss_ready),  256'(0));
    @(negedge clk);
    checkOutput("ready_after", 256'(miss_ready),  256'(1));
    checkOutput("done_pulse",  256'(refill_done), 256'(0));
    if (hold) checkOutput("held_not_yet", 256'(mem_req_valid), 256'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t va, vb, vr;
    int   waited;

    //          addr           sv       beats dly gaps base          wen      err
    vecs[0] = '{32'h1234_5660, 4'b1011, 8,    0,  1'b0, 32'h0000_0000, 4'b0100, 1'b0};
    vecs[1] = '{32'h0000_1000, 4'b1111, 8,    0,  1'b0, 32'h0000_0100, 4'b0001, 1'b0};
    vecs[2] = '{32'h0000_1020, 4'b1111, 8,    0,  1'b0, 32'h0000_0200, 4'b0010, 1'b0};
    vecs[3] = '{32'h0000_1040, 4'b1111, 8,    0,  1'b0, 32'h0000_0300, 4'b0100, 1'b0};
    vecs[4] = '{32'h0000_1060, 4'b1111, 8,    0,  1'b0, 32'h0000_0400, 4'b1000, 1'b0};
    vecs[5] = '{32'h0000_1080, 4'b1111, 8,    0,  1'b0, 32'h0000_0500, 4'b0001, 1'b0};
    vecs[6] = '{32'h1234_5660, 4'b1011, 8,    5,  1'b1, 32'h0000_0000, 4'b0100, 1'b0};
    vecs[7] = '{32'hCAFE_00A0, 4'b0111, 5,    0,  1'b0, 32'hA000_0000, 4'b1000, 1'b1};
    vecs[8] = '{32'hBEEF_01C0, 4'b0000, 10,   1,  1'b1, 32'hB000_0000, 4'b0001, 1'b1};

    rst             = 1'b0;
    miss_valid      = 1'b0;
    miss_addr       = '0;
    set_valid       = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    mem_rdata_last  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_miss_ready",  256'(miss_ready),      256'(1));
    checkOutput("rst_req_valid",   256'(mem_req_valid),   256'(0));
    checkOutput("rst_rdata_ready", 256'(mem_rdata_ready), 256'(0));
    checkOutput("rst_done",        256'(refill_done),     256'(0));
    checkOutput("rst_err",         256'(refill_err),      256'(0));
    checkOutput("rst_wdata",       line_wdata,            256'(0));
    checkOutput("rst_len",         256'(mem_req_len),     256'(7));
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], 1'b0, 32'h0);
    end

    // Abort a refill of a full set after three beats; the reset must also clear the pointer.
    $display("[TB] reset during receive");
    waited = 0;
    while (miss_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0040;
    set_valid  = 4'b1111;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'h7700 + 32'(b);
      @(posedge clk); #1;
    end
    mem_rdata_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_wen",         256'(line_wen),        256'(0));
    checkOutput("abort_done",        256'(refill_done),     256'(0));
    checkOutput("abort_miss_ready",  256'(miss_ready),      256'(1));
    checkOutput("abort_rdata_ready", 256'(mem_rdata_ready), 256'(0));
    vr = '{32'h0000_0040, 4'b1111, 8, 0, 1'b0, 32'h0000_0600, 4'b0001, 1'b0};
    applyStimulus(vr, 1'b0, 32'h0);

    // Second miss held high through the first refill; it must be taken only afterwards.
    $display("[TB] miss held during refill");
    va = '{32'h0000_2020, 4'b1101, 8, 2, 1'b1, 32'h0000_0800, 4'b0010, 1'b0};
    vb = '{32'h0ABC_DEE0, 4'b1110, 8, 0, 1'b0, 32'h0000_0900, 4'b0001, 1'b0};
    applyStimulus(va, 1'b1, vb.addr);
    applyStimulus(vb, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 256'(sb.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
